// File: rtl/ethernet_pkg.sv
// Shared encodings for the CSMA/CD frame transmitter: channel symbols, LLC status,
// request levels and the transmitter state type.
package ethernet_pkg;

  localparam logic [1:0] SYM_JAM = 2'd0;
  localparam logic [1:0] SYM_F   = 2'd1;
  localparam logic [1:0] SYM_ND  = 2'd2;

  localparam logic [1:0] ST_FAIL    = 2'd0;
  localparam logic [1:0] ST_SUCCESS = 2'd1;
  localparam logic [1:0] ST_NA      = 2'd2;

  localparam logic REQ   = 1'b1;
  localparam logic NOREQ = 1'b0;

  typedef enum logic [2:0] {
    IDLE, DEFER, TX, WAIT, JAM, BACKOFF, DONE, HOLD
  } ft_state_t;

endpackage

// File: rtl/backoff_lfsr.sv
// Free-running Fibonacci LFSR (x^16+x^14+x^13+x^11+1 for WIDTH=16) feeding backoff slot
// selection; an all-zero seed would lock up, so it is replaced by 1.
module backoff_lfsr #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(16'hACE1)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] RST_VAL = (SEED == '0) ? WIDTH'(1) : SEED;

  logic [WIDTH-1:0] value_q, value_d;

  always_comb begin
    value_d = {value_q[WIDTH-2:0],
               value_q[WIDTH-1] ^ value_q[WIDTH-3] ^ value_q[WIDTH-4] ^ value_q[WIDTH-6]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) value_q <= RST_VAL;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/csma_frame_tx.sv
// CSMA/CD frame transmitter: defers on carrier, sends a frame, jams on collision and
// retries with truncated binary exponential backoff until Success or Fail.
module csma_frame_tx
  import ethernet_pkg::*;
#(
  parameter int unsigned FRAME_LEN    = 4,
  parameter int unsigned JAM_LEN      = 2,
  parameter int unsigned IFG          = 2,
  parameter int unsigned PROP_WIN     = 4,
  parameter int unsigned MAX_ATTEMPTS = 4,
  parameter int unsigned BACKOFF_CAP  = 3,
  parameter int unsigned SLOT         = 1,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  output logic [1:0] ack,
  output logic [1:0] sym_out,
  input  logic       cs,
  input  logic       cd,
  output logic       busy,
  output logic [3:0] attempts
);

  localparam int unsigned GW     = $clog2(IFG) + 1;
  localparam int unsigned TW     = $clog2(FRAME_LEN) + 1;
  localparam int unsigned WW     = $clog2(PROP_WIN) + 1;
  localparam int unsigned JW     = $clog2(JAM_LEN) + 1;
  localparam int unsigned BO_MAX = ((32'd1 << BACKOFF_CAP) - 32'd1) * SLOT;
  localparam int unsigned BW     = $clog2(BO_MAX) + 1;

  ft_state_t     state_q, state_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [TW-1:0] tx_q, tx_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [JW-1:0] jam_q, jam_d;
  logic [BW-1:0] bo_q, bo_d;
  logic [1:0]    sym_q, sym_d, ack_q, ack_d;
  logic          busy_q, busy_d;
  logic [3:0]    att_q, att_d, att_inc, bo_exp;
  logic [15:0]   lfsr_val;
  logic [31:0]   bo_load;

  backoff_lfsr #(
    .WIDTH (16),
    .SEED  (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr_val)
  );

  // Backoff length for the attempt that is about to be counted: LFSR low bits, exponent capped.
  always_comb begin
    att_inc = att_q + 4'd1;
    bo_exp  = (32'(att_inc) > BACKOFF_CAP) ? 4'(BACKOFF_CAP) : att_inc;
    bo_load = (32'(lfsr_val) & ((32'd1 << bo_exp) - 32'd1)) * SLOT;
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    tx_d    = tx_q;
    wait_d  = wait_q;
    jam_d   = jam_q;
    bo_d    = bo_q;
    sym_d   = SYM_ND;
    ack_d   = ST_NA;
    att_d   = att_q;
    unique case (state_q)
      IDLE: begin
        if (req == REQ) begin
          state_d = DEFER;
          gap_d   = '0;
        end
      end
      DEFER: begin
        if (cs) begin
          gap_d = '0;
        end else begin
          gap_d = gap_q + 1'b1;
          if (gap_d == GW'(IFG)) begin
            state_d = TX;
            sym_d   = SYM_F;
            tx_d    = TW'(1);
          end
        end
      end
      TX: begin
        if (cd) begin
          state_d = JAM;
          sym_d   = SYM_JAM;
          jam_d   = JW'(1);
        end else if (tx_q == TW'(FRAME_LEN)) begin
          state_d = WAIT;
          wait_d  = WW'(1);
        end else begin
          sym_d = SYM_F;
          tx_d  = tx_q + 1'b1;
        end
      end
      WAIT: begin
        if (cd) begin
          state_d = JAM;
          sym_d   = SYM_JAM;
          jam_d   = JW'(1);
        end else if (wait_q == WW'(PROP_WIN)) begin
          state_d = DONE;
          ack_d   = ST_SUCCESS;
          att_d   = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      JAM: begin
        if (jam_q == JW'(JAM_LEN)) begin
          att_d = att_inc;
          if (att_inc == 4'(MAX_ATTEMPTS)) begin
            state_d = DONE;
            ack_d   = ST_FAIL;
            att_d   = '0;
          end else if (bo_load == 32'd0) begin
            state_d = DEFER;
            gap_d   = '0;
          end else begin
            state_d = BACKOFF;
            bo_d    = BW'(bo_load);
          end
        end else begin
          sym_d = SYM_JAM;
          jam_d = jam_q + 1'b1;
        end
      end
      BACKOFF: begin
        if (bo_q == BW'(1)) begin
          state_d = DEFER;
          gap_d   = '0;
        end else begin
          bo_d = bo_q - 1'b1;
        end
      end
      DONE:    state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) && (state_d != HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gap_q   <= '0;
      tx_q    <= '0;
      wait_q  <= '0;
      jam_q   <= '0;
      bo_q    <= '0;
      sym_q   <= SYM_ND;
      ack_q   <= ST_NA;
      busy_q  <= 1'b0;
      att_q   <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      tx_q    <= tx_d;
      wait_q  <= wait_d;
      jam_q   <= jam_d;
      bo_q    <= bo_d;
      sym_q   <= sym_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      att_q   <= att_d;
    end
  end

  assign sym_out  = sym_q;
  assign ack      = ack_q;
  assign busy     = busy_q;
  assign attempts = att_q;

endmodule

// File: tb/tb_csma_frame_tx.sv
// Bench for csma_frame_tx: directed vector tables, directed collision sequences and random
// channel activity checked against a sequence-level model of a request's lifetime.
module tb_csma_frame_tx;
  import ethernet_pkg::*;

  localparam int NV           = 512;
  localparam int FRAME_LEN    = 4;
  localparam int JAM_LEN      = 2;
  localparam int IFG          = 2;
  localparam int PROP_WIN     = 4;
  localparam int MAX_ATTEMPTS = 4;
  localparam int BACKOFF_CAP  = 3;
  localparam int SLOT         = 1;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       cs  = 1'b0;
  logic       cd  = 1'b0;
  logic [1:0] ack, sym_out;
  logic       busy;
  logic [3:0] attempts;

  typedef struct packed {
    logic [1:0] sym;
    logic [1:0] ack;
    logic       busy;
    logic [3:0] att;
  } exp_t;

  typedef struct {
    bit   rf;
    logic rq, c, d;
    exp_t x;
  } vec_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  csma_frame_tx dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .ack      (ack),
    .sym_out  (sym_out),
    .cs       (cs),
    .cd       (cd),
    .busy     (busy),
    .attempts (attempts)
  );

  function automatic exp_t mk(input logic [1:0] s, input logic [1:0] a, input logic b,
                              input int n);
    mk.sym  = s;
    mk.ack  = a;
    mk.busy = b;
    mk.att  = 4'(n);
  endfunction

  function automatic void add(input bit rf, input logic rq, input logic c, input logic d,
                              input exp_t x);
    vec_t v;
    v.rf = rf; v.rq = rq; v.c = c; v.d = d; v.x = x;
    vecs.push_back(v);
  endfunction

  // Reference LFSR: polynomial taps as a mask, value seen at the n-th edge after reset.
  function automatic logic [15:0] lfsr_at(input int n);
    logic [15:0] v;
    v = SEED;
    for (int i = 0; i < n; i++) v = {v[14:0], ^(v & 16'hB400)};
    return v;
  endfunction

  task automatic check(input string name, input exp_t want);
    exp_t act;
    act = {sym_out, ack, busy, attempts};
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got sym=%0d ack=%0d busy=%0d att=%0d, want sym=%0d ack=%0d busy=%0d att=%0d",
               name, act.sym, act.ack, act.busy, act.att, want.sym, want.ack, want.busy,
               want.att);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = 1'b0; cs = 1'b0; cd = 1'b0;
    #1 check("reset", mk(SYM_ND, ST_NA, 0, 0));
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  // Expected outputs after each edge of one request (edge 0 = req seen in IDLE).
  task automatic build_exp(input bit [NV-1:0] csv, input bit [NV-1:0] cdv, input bit hold);
    int t, gap, att, p, k, slots;
    bit fin, hit;
    exp_q.delete();
    t = 0; att = 0; fin = 0;
    exp_q.push_back(mk(SYM_ND, ST_NA, 1, 0));
    while (!fin) begin
      gap = 0;
      while (gap < IFG) begin
        t++;
        gap = csv[t] ? 0 : gap + 1;
        exp_q.push_back(mk((gap == IFG) ? SYM_F : SYM_ND, ST_NA, 1, att));
      end
      hit = 0; p = 0;
      while (!hit && p < FRAME_LEN + PROP_WIN) begin
        p++; t++;
        if (cdv[t]) hit = 1;
        else if (p == FRAME_LEN + PROP_WIN) exp_q.push_back(mk(SYM_ND, ST_SUCCESS, 1, 0));
        else exp_q.push_back(mk((p < FRAME_LEN) ? SYM_F : SYM_ND, ST_NA, 1, att));
      end
      if (!hit) begin
        fin = 1;
      end else begin
        exp_q.push_back(mk(SYM_JAM, ST_NA, 1, att));
        repeat (JAM_LEN - 1) begin
          t++;
          exp_q.push_back(mk(SYM_JAM, ST_NA, 1, att));
        end
        t++; att++;
        if (att == MAX_ATTEMPTS) begin
          exp_q.push_back(mk(SYM_ND, ST_FAIL, 1, 0));
          fin = 1;
        end else begin
          k = (att < BACKOFF_CAP) ? att : BACKOFF_CAP;
          slots = int'(lfsr_at(t)) % (1 << k);
          exp_q.push_back(mk(SYM_ND, ST_NA, 1, att));
          repeat (slots * SLOT) begin
            t++;
            exp_q.push_back(mk(SYM_ND, ST_NA, 1, att));
          end
        end
      end
    end
    exp_q.push_back(mk(SYM_ND, ST_NA, 0, 0));
    exp_q.push_back(mk(SYM_ND, ST_NA, 0, 0));
    exp_q.push_back(mk(SYM_ND, ST_NA, hold, 0));
  endtask

  task automatic run_trial(input bit [NV-1:0] csv, input bit [NV-1:0] cdv, input bit hold,
                           input bit rf, input string name);
    if (rf) do_reset();
    build_exp(csv, cdv, hold);
    foreach (exp_q[e]) begin
      req = (e == 0) || hold;
      cs  = csv[e];
      cd  = cdv[e];
      @(posedge clk);
      @(negedge clk);
      check($sformatf("%s e%0d", name, e), exp_q[e]);
    end
    req = 1'b0; cs = 1'b0; cd = 1'b0;
  endtask

  initial begin
    bit [NV-1:0] z, v1, v2;
    z = '0;

    // Clean frame with req held, then the two deferral patterns.
    for (int e = 0; e < 14; e++)
      add(e == 0, 1, 0, 0, mk((e >= 2 && e <= 5) ? SYM_F : SYM_ND,
                              (e == 10) ? ST_SUCCESS : ST_NA, !(e == 11 || e == 12), 0));
    for (int e = 0; e < 9; e++)
      add(e == 0, 1, e <= 5, 0, mk((e >= 7) ? SYM_F : SYM_ND, ST_NA, 1, 0));
    for (int e = 0; e < 11; e++)
      add(e == 0, 1, (e <= 5) || (e == 7), 0, mk((e >= 9) ? SYM_F : SYM_ND, ST_NA, 1, 0));

    foreach (vecs[i]) begin
      if (vecs[i].rf) do_reset();
      req = vecs[i].rq; cs = vecs[i].c; cd = vecs[i].d;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("tbl%0d", i), vecs[i].x);
    end

    v1 = '0; v1[3] = 1'b1;
    run_trial(z, v1, 0, 1, "collision");
    v1 = '0; v1[8] = 1'b1;
    run_trial(z, v1, 0, 1, "late_coll");
    v1 = '1;
    run_trial(z, v1, 1, 1, "exhaust");

    // Asynchronous reset while transmitting, then a fresh request.
    do_reset();
    for (int e = 0; e < 4; e++) begin
      req = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    check("pre_rst_tx", mk(SYM_F, ST_NA, 1, 0));
    #1 rst = 1'b1; req = 1'b0;
    #1 check("async_rst", mk(SYM_ND, ST_NA, 0, 0));
    #1 rst = 1'b0;
    run_trial(z, z, 0, 0, "post_rst");

    for (int n = 0; n < 25; n++) begin
      v1 = '0; v2 = '0;
      for (int i = 0; i < 200; i++) begin
        v1[i] = ($urandom_range(3) == 0);
        v2[i] = ($urandom_range(11) == 0);
      end
      run_trial(v1, v2, 1'($urandom_range(1)), 1, $sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
